// File: rtl/sram_array.sv
// Single-port synchronous SRAM with per-bit active-low write mask, registered read
// (latency 1 or 2) and a post-reset sequencer that zeroes every word before use.
module sram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              bRst,
    input  logic              bCS,
    input  logic              bWE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] InData,
    input  logic [DATA_W-1:0] bBM,
    output logic [DATA_W-1:0] OutData,
    output logic              RdValid,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam bit TWO_STAGE = (RD_LAT == 2);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("sram_array: RD_LAT must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_wa_s;
    logic [DATA_W-1:0]   mem_wd_s;
    logic                rd_en_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                s1_vld_q;
    logic [DATA_W-1:0]   s1_data_q;
    logic                fin_vld_s;
    logic [DATA_W-1:0]   fin_data_s;
    logic [DATA_W-1:0]   out_q;
    logic                rdv_q;

    assign rd_word_s = mem_q[Addr];

    // Sequencer next state plus single write-port arbitration (clear vs. user write).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_we_s = 1'b0;
        mem_wa_s = Addr;
        mem_wd_s = '0;
        rd_en_s  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                mem_wa_s = cnt_q;
                mem_wd_s = '0;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (!bCS) begin
                    if (!bWE) begin
                        mem_we_s = 1'b1;
                        mem_wd_s = (rd_word_s & bBM) | (InData & ~bBM);
                    end else begin
                        rd_en_s = 1'b1;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Final read stage source: straight from the array, or from the stage-1 register.
    always_comb begin
        fin_vld_s  = rd_en_s;
        fin_data_s = rd_word_s;
        if (TWO_STAGE) begin
            fin_vld_s  = s1_vld_q;
            fin_data_s = s1_data_q;
        end else begin
            fin_vld_s  = rd_en_s;
            fin_data_s = rd_word_s;
        end
    end

    // Storage needs no reset: the clear sequencer zeroes it before any access.
    always_ff @(posedge Clk) begin
        if (bRst && mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    // Control state and read pipeline; reset drops any in-flight read.
    always_ff @(posedge Clk) begin
        if (!bRst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            out_q     <= '0;
            rdv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= rd_en_s;
            if (rd_en_s) begin
                s1_data_q <= rd_word_s;
            end
            rdv_q <= fin_vld_s;
            if (fin_vld_s) begin
                out_q <= fin_data_s;
            end
        end
    end

    assign OutData = out_q;
    assign RdValid = rdv_q;
    assign Busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sram_array.sv
// Directed bench: drives one RD_LAT=1 and one RD_LAT=2 instance from shared inputs.
module tb_sram_array;

    logic       Clk;
    logic       bRst;
    logic       bCS;
    logic       bWE;
    logic [3:0] Addr;
    logic [7:0] InData;
    logic [7:0] bBM;
    logic [7:0] out1, out2;
    logic       rv1, rv2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    sram_array #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) dut1 (
        .Clk(Clk), .bRst(bRst), .bCS(bCS), .bWE(bWE), .Addr(Addr),
        .InData(InData), .bBM(bBM), .OutData(out1), .RdValid(rv1), .Busy(busy1)
    );

    sram_array #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) dut2 (
        .Clk(Clk), .bRst(bRst), .bCS(bCS), .bWE(bWE), .Addr(Addr),
        .InData(InData), .bBM(bBM), .OutData(out2), .RdValid(rv2), .Busy(busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bCS = 1'b1;
        bWE = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        bCS = 1'b0; bWE = 1'b0; Addr = a; InData = d; bBM = m;
        step();
        idle();
    endtask

    // vp = {rv1@+1, rv2@+1, rv1@+2, rv2@+2}; a correct read gives 4'b1001
    task automatic rd(input logic [3:0] a, output logic [7:0] d1, output logic [7:0] d2,
                      output logic [3:0] vp);
        bCS = 1'b0; bWE = 1'b1; Addr = a;
        step();
        d1 = out1; vp[3] = rv1; vp[2] = rv2;
        idle();
        step();
        d2 = out2; vp[1] = rv1; vp[0] = rv2;
    endtask

    task automatic wait_clear(input string name);
        int n1 = 0;
        int n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i % 2 == 1) begin
                bCS = 1'b0; bWE = 1'b1; Addr = 4'(i);
            end else begin
                bCS = 1'b0; bWE = 1'b0; Addr = 4'd0; InData = 8'hFF; bBM = 8'h00;
            end
            step();
            checks++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_rdvalid cycle %0d: got %b%b expected 00", name, i, rv1, rv2);
            end
            if (!busy1 && n1 == 0) n1 = i;
            if (!busy2 && n2 == 0) n2 = i;
            if (n1 != 0 && n2 != 0) break;
        end
        idle();
        checks++;
        if (n1 != 16 || n2 != 16) begin
            errors++;
            $display("FAIL %s_clear_len: got %0d/%0d cycles expected 16", name, n1, n2);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        bRst = 1'b0; idle(); Addr = 4'd0; InData = 8'h00; bBM = 8'hFF;
        step(); step();
        checks++;
        if (out1 !== 8'h00 || out2 !== 8'h00 || rv1 !== 1'b0 || rv2 !== 1'b0 ||
            busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got out %h/%h rv %b%b busy %b%b expected 00/00 00 11",
                     out1, out2, rv1, rv2, busy1, busy2);
        end
        bRst = 1'b1;
        wait_clear("reset");
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d1, d2, vp);
            checks++;
            if (d1 !== 8'h00 || d2 !== 8'h00 || vp !== 4'b1001) begin
                errors++;
                $display("FAIL reset_zero[%0d]: got %h/%h vp %b expected 00/00 1001", a, d1, d2, vp);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        wr(4'd3, 8'hA5, 8'h00);
        wr(4'd15, 8'h3C, 8'h00);
        rd(4'd3, d1, d2, vp);
        checks++;
        if (d1 !== 8'hA5 || d2 !== 8'hA5 || vp !== 4'b1001) begin
            errors++;
            $display("FAIL wr_rd_3: got %h/%h vp %b expected a5/a5 1001", d1, d2, vp);
        end
        rd(4'd15, d1, d2, vp);
        checks++;
        if (d1 !== 8'h3C || d2 !== 8'h3C || vp !== 4'b1001) begin
            errors++;
            $display("FAIL wr_rd_15: got %h/%h vp %b expected 3c/3c 1001", d1, d2, vp);
        end
    endtask

    task automatic test_back_to_back();
        bCS = 1'b0; bWE = 1'b1; Addr = 4'd3;
        step();
        Addr = 4'd15;
        step();
        checks++;
        if (out1 !== 8'h3C || rv1 !== 1'b1 || out2 !== 8'hA5 || rv2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_mid: got %h/%b %h/%b expected 3c/1 a5/1", out1, rv1, out2, rv2);
        end
        idle();
        step();
        checks++;
        if (rv1 !== 1'b0 || out2 !== 8'h3C || rv2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail: got rv1 %b out2 %h rv2 %b expected 0 3c 1", rv1, out2, rv2);
        end
    endtask

    task automatic test_mask();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        wr(4'd5, 8'hFF, 8'h00);
        wr(4'd5, 8'h00, 8'hF0);
        rd(4'd5, d1, d2, vp);
        checks++;
        if (d1 !== 8'hF0 || d2 !== 8'hF0) begin
            errors++;
            $display("FAIL mask_partial: got %h/%h expected f0/f0", d1, d2);
        end
        wr(4'd5, 8'h0F, 8'hFF);
        rd(4'd5, d1, d2, vp);
        checks++;
        if (d1 !== 8'hF0 || d2 !== 8'hF0) begin
            errors++;
            $display("FAIL mask_none: got %h/%h expected f0/f0", d1, d2);
        end
    endtask

    task automatic test_hazard();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        wr(4'd7, 8'h11, 8'h00);
        bCS = 1'b0; bWE = 1'b1; Addr = 4'd7;
        step();
        bWE = 1'b0; InData = 8'h22; bBM = 8'h00;
        step();
        idle();
        checks++;
        if (out2 !== 8'h11 || rv2 !== 1'b1 || out1 !== 8'h11) begin
            errors++;
            $display("FAIL hazard_old: got %h/%b (lat1 %h) expected 11/1 (11)", out2, rv2, out1);
        end
        rd(4'd7, d1, d2, vp);
        checks++;
        if (d1 !== 8'h22 || d2 !== 8'h22) begin
            errors++;
            $display("FAIL hazard_new: got %h/%h expected 22/22", d1, d2);
        end
    endtask

    task automatic test_midop_reset();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        wr(4'd9, 8'h77, 8'h00);
        bCS = 1'b0; bWE = 1'b1; Addr = 4'd9;
        step();
        idle();
        bRst = 1'b0;
        step();
        checks++;
        if (rv2 !== 1'b0 || out2 !== 8'h00 || rv1 !== 1'b0 || out1 !== 8'h00 ||
            busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL midop_flush: got out %h/%h rv %b%b busy %b%b expected 00/00 00 11",
                     out1, out2, rv1, rv2, busy1, busy2);
        end
        bRst = 1'b1;
        wait_clear("midop");
        rd(4'd9, d1, d2, vp);
        checks++;
        if (d1 !== 8'h00 || d2 !== 8'h00 || vp !== 4'b1001) begin
            errors++;
            $display("FAIL midop_cleared: got %h/%h vp %b expected 00/00 1001", d1, d2, vp);
        end
    endtask

    task automatic test_idle_hold();
        logic [7:0] d1, d2;
        logic [3:0] vp;
        wr(4'd2, 8'h5A, 8'h00);
        rd(4'd2, d1, d2, vp);
        checks++;
        if (d1 !== 8'h5A || d2 !== 8'h5A) begin
            errors++;
            $display("FAIL idle_src: got %h/%h expected 5a/5a", d1, d2);
        end
        for (int i = 0; i < 10; i++) begin
            Addr = 4'(i); InData = 8'(i * 37); bBM = 8'(i);
            step();
            checks++;
            if (out1 !== 8'h5A || out2 !== 8'h5A || rv1 !== 1'b0 || rv2 !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got %h/%h rv %b%b expected 5a/5a 00", i, out1, out2, rv1, rv2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_mask();
        test_hazard();
        test_midop_reset();
        test_idle_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
